// File: rtl/wdog_timer.sv
// ---------------------------------------------------------------------------
// wdog_timer
//
// Host-communication watchdog. Every valid host packet (wdog_refresh) restarts
// the countdown; if no packet arrives within the programmed period the
// wdog_timeout flag latches and stays set until software clears it through
// the status register. The block also measures the spacing between host
// refreshes and reports it as a coarse 3-bit bucket for the status LED.
//
// Time base: a free-running prescaler of PRESCALE_W bits produces one tick
// every 2^PRESCALE_W sysclk cycles. Periods and intervals are counted in ticks.
//
// Ports:
//   sysclk              system clock
//   reset               synchronous, active-high reset
//   reg_waddr           register write address
//   reg_wdata           register write data
//   reg_wen             single-cycle register write strobe
//   wdog_refresh        single-cycle pulse per valid host packet
//   wdog_timeout        latched timeout flag
//   wdog_period_status  bucketed last refresh interval (0 = disabled, 7 = timed out)
//   wdog_period_led     1 when the LED should display wdog_period_status
//   wdog_clear          one-cycle pulse after a timeout-clear write
//   wdog_period         currently programmed period in ticks
// ---------------------------------------------------------------------------
module wdog_timer #(
    parameter int          PRESCALE_W  = 8,
    parameter logic [15:0] ADDR_STATUS = 16'h0000,
    parameter logic [15:0] ADDR_WDOG   = 16'h0003,
    parameter int          CLR_BIT     = 19
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [15:0] reg_waddr,
    input  logic [31:0] reg_wdata,
    input  logic        reg_wen,
    input  logic        wdog_refresh,
    output logic        wdog_timeout,
    output logic [2:0]  wdog_period_status,
    output logic        wdog_period_led,
    output logic        wdog_clear,
    output logic [15:0] wdog_period
);

    localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);
    localparam logic [15:0]           CNT_MAX = 16'hFFFF;

    logic [PRESCALE_W-1:0] prescaler;
    logic [15:0]           elapsed;
    logic [15:0]           interval;
    logic [15:0]           period;
    logic                  timeout_q;
    logic                  led_q;
    logic                  clear_q;
    logic [2:0]            bucket_q;

    logic                  wdog_wr;
    logic                  status_clr;
    logic                  tick;
    logic                  restart;
    logic                  expire;
    logic [2:0]            bucket_next;
    logic                  unused_wdata;

    // Only bits [15:0], bit 31 and CLR_BIT of the write data carry meaning.
    assign unused_wdata = ^reg_wdata;

    // Register decode and time-base events. A timeout-clear write, a period
    // write and a host refresh all restart the countdown from zero. Expiry is
    // evaluated against elapsed+1 in 17 bits, so the flag rises on the tick
    // that completes the period and a saturated elapsed cannot wrap.
    always_comb begin
        wdog_wr    = reg_wen && (reg_waddr == ADDR_WDOG);
        status_clr = reg_wen && (reg_waddr == ADDR_STATUS) && reg_wdata[CLR_BIT];
        tick       = &prescaler;
        restart    = status_clr || wdog_wr || wdog_refresh;
        expire     = tick && (period != 16'h0000) &&
                     (({1'b0, elapsed} + 17'd1) >= {1'b0, period});
    end

    // Interval bucketing: each bucket spans a factor of four in ticks, so the
    // LED can show the rough refresh rate from about 80 us up to tens of ms.
    always_comb begin
        bucket_next = 3'd6;
        if (interval < 16'd16) begin
            bucket_next = 3'd1;
        end else if (interval < 16'd64) begin
            bucket_next = 3'd2;
        end else if (interval < 16'd256) begin
            bucket_next = 3'd3;
        end else if (interval < 16'd1024) begin
            bucket_next = 3'd4;
        end else if (interval < 16'd4096) begin
            bucket_next = 3'd5;
        end
    end

    // Prescaler and the two tick counters. The elapsed counter drives expiry
    // and restarts on any restart event; the interval counter only restarts
    // on a host refresh, because it measures host activity and must not be
    // disturbed by register traffic. Both saturate instead of wrapping so a
    // very long silence never looks like a short one.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            prescaler <= '0;
            elapsed   <= 16'h0000;
            interval  <= 16'h0000;
            bucket_q  <= 3'd0;
        end else begin
            if (restart) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + PRE_ONE;
            end

            if (restart) begin
                elapsed <= 16'h0000;
            end else if (tick && (elapsed != CNT_MAX)) begin
                elapsed <= elapsed + 16'd1;
            end

            if (wdog_refresh) begin
                bucket_q <= bucket_next;
                interval <= 16'h0000;
            end else if (tick && (interval != CNT_MAX)) begin
                interval <= interval + 16'd1;
            end
        end
    end

    // Configuration and the timeout latch. Same-cycle precedence is
    // clear write, then period write, then refresh, then expiry: a refresh
    // or period write landing on the expiry tick wins and no timeout is set,
    // but neither of them ever releases a latched timeout -- only the
    // explicit clear write does. wdog_clear is the registered clear strobe,
    // so it pulses on the edge after the write is sampled.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            period    <= 16'h0000;
            led_q     <= 1'b0;
            timeout_q <= 1'b0;
            clear_q   <= 1'b0;
        end else begin
            clear_q <= status_clr;

            if (!status_clr && wdog_wr) begin
                period <= reg_wdata[15:0];
                led_q  <= reg_wdata[31];
            end

            if (status_clr) begin
                timeout_q <= 1'b0;
            end else if (!wdog_wr && !wdog_refresh && expire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Status overrides sit on top of the stored bucket: a latched timeout
    // always shows 7, and a disabled watchdog shows 0.
    always_comb begin
        wdog_period_status = bucket_q;
        if (timeout_q) begin
            wdog_period_status = 3'd7;
        end else if (period == 16'h0000) begin
            wdog_period_status = 3'd0;
        end
    end

    assign wdog_timeout    = timeout_q;
    assign wdog_period_led = led_q;
    assign wdog_clear      = clear_q;
    assign wdog_period     = period;

endmodule

// File: doc/wdog_timer.md
Name: wdog_timer

Overview:
- Host-communication watchdog inside the FPGA1394V3 board module, directly upstream of the QLA module.
- Produces the wdog_timeout, wdog_period_status, wdog_period_led and wdog_clear signals that QLA consumes to disable amplifiers and drive the status LED.
- Restarted by every valid host packet; configured and cleared through writes on the shared register write bus (reg_waddr/reg_wdata/reg_wen).
- Also measures the interval between host refreshes and reports it as a 3-bit bucket.

Parameters:
- PRESCALE_W, 8, prescaler width; one tick = 2^PRESCALE_W sysclk cycles (256 cycles, about 5.21 us at 49.152 MHz).
- ADDR_STATUS, 16'h0000, status register write address.
- ADDR_WDOG, 16'h0003, watchdog period register write address.
- CLR_BIT, 19, bit of status-register write data that clears a latched timeout.

Ports:
- sysclk  in  1  system clock, 49.152 MHz.
- reset  in  1  synchronous, active-high reset.
- reg_waddr  in  16  register write address.
- reg_wdata  in  32  register write data.
- reg_wen  in  1  single-cycle register write strobe.
- wdog_refresh  in  1  single-cycle pulse on each valid host packet (Firewire or Ethernet).
- wdog_timeout  out  1  latched timeout flag.
- wdog_period_status  out  3  bucketed last refresh interval.
- wdog_period_led  out  1  1 means the LED displays wdog_period_status.
- wdog_clear  out  1  one-cycle pulse when a timeout is cleared.
- wdog_period  out  16  current period, in ticks, for register readback.

Behaviour:
- Reset: every output 0, period 0, prescaler 0, elapsed counter 0, interval counter 0.
- Register writes are decoded only when reg_wen=1 and reg_waddr matches exactly.
- WDOG write: period <= wdata[15:0]; wdog_period_led <= wdata[31]; prescaler and elapsed counter cleared; wdog_timeout unchanged.
- Status write with wdata[CLR_BIT]=1: wdog_timeout <= 0; prescaler and elapsed counter cleared; wdog_clear=1 for exactly one cycle, on the edge after the write.
- Tick: the prescaler increments every cycle; a tick occurs when it wraps from all-ones to 0.
- Elapsed counter: increments on each tick and saturates at 16'hFFFF.
- Interval counter: increments on each tick and saturates at 16'hFFFF.
- Refresh: the prescaler and elapsed counter clear on the same edge. A refresh never clears wdog_timeout; a timeout is a safety latch.
- Expiry: with period != 0, if a tick occurs and elapsed+1 >= period, wdog_timeout <= 1 on that edge. Consequence: timeout goes high exactly period*256 cycles after the last clear, refresh or WDOG write.
- Period 0 disables expiry. An already-latched timeout stays latched.
- Interval measurement: on each refresh, the interval counter (ticks since the previous refresh) is bucketed into wdog_period_status, then the interval counter clears. Bucket rule, I = interval in ticks:
  - 1: I<16
  - 2: I<64
  - 3: I<256
  - 4: I<1024
  - 5: I<4096
  - 6: I>=4096
- Status overrides: wdog_period_status = 0 while period = 0, and 7 while wdog_timeout = 1. Both overrides are combinational over the stored bucket.
- The first refresh after reset reports the interval since reset.
- Same-cycle priority, highest first: reset > clear write > WDOG write > refresh > expiry.
  - Refresh in the expiry cycle: no timeout.
  - Clear write in the expiry cycle: timeout stays 0 and wdog_clear pulses.
- A clear write while no timeout is latched still pulses wdog_clear and restarts the counters.
- Reset mid-count: everything returns to reset values; the watchdog is disabled until the period is rewritten.

Test Plan:
- Reset, write WDOG=0x00000004, no refresh -> wdog_timeout rises on cycle 1024 after the write edge (not 1023); wdog_period_status=7; wdog_period=4.
- Period 4, refresh pulse every 1000 cycles for 20 refreshes -> wdog_timeout stays 0; wdog_period_status=1 (interval 3 ticks).
- Timeout latched, then refresh pulses -> wdog_timeout stays 1. Then status write 0x00080000 -> wdog_timeout=0, wdog_clear high for one cycle, next timeout 1024 cycles later.
- Refresh asserted on the exact expiry cycle (cycle 1024) -> no timeout. Separately, clear write on the expiry cycle -> no timeout and a wdog_clear pulse.
- Period 0xFFFF, refreshes spaced 70 ticks, then 300 ticks, then 5000 ticks -> status 3, then 4, then 6. WDOG write 0x80000000 -> status 0, wdog_period_led=1, no timeout for 70000 ticks.
- Assert reset while wdog_timeout=1 and period=4 -> all outputs 0 the next cycle; no timeout ever without a new WDOG write.
